// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: holds ALU operands for the op-class latency, then
// captures the ALU result and presents it on a valid/ready writeback port.
module alu_exec_ctrl #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [9:0]  in_opcode,
  input  logic [4:0]  in_regA,
  input  logic [11:0] in_regB,
  input  logic [4:0]  in_regDest,
  input  logic [63:0] in_regA_value,
  input  logic [63:0] in_regB_value,
  output logic [9:0]  alu_opcode,
  output logic [4:0]  alu_regA,
  output logic [11:0] alu_regB,
  output logic [4:0]  alu_regDest,
  output logic [63:0] alu_regA_value,
  output logic [63:0] alu_regB_value,
  input  logic [63:0] alu_data_out,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        wb_wr_en,
  output logic        busy
);

  localparam int MAX_L = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW    = $clog2(MAX_L + 1);
  localparam logic [CW-1:0] MUL_M1 = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, WB} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    rst_sync;
  logic          run;
  logic          can_take;
  logic          accept;
  logic          capt;
  logic          f7_m;
  logic          is_mul;
  logic          is_div;
  logic          is_sup;
  logic [CW-1:0] lat_m1;
  logic          wr_pend;

  // Assertion is immediate; release waits for the two-flop chain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign run = rst_sync[1];

  always_comb begin
    f7_m   = (in_regB[11:5] == 7'h01);
    is_mul = f7_m & (in_opcode inside {10'h033, 10'h0b3, 10'h133, 10'h1b3, 10'h03b});
    is_div = (f7_m & (in_opcode inside {10'h233, 10'h2b3, 10'h333, 10'h3b3, 10'h2bb}))
           | (in_opcode inside {10'h23b, 10'h33b, 10'h3bb});
    is_sup = in_opcode inside {10'h033, 10'h0b3, 10'h133, 10'h1b3, 10'h03b,
                               10'h233, 10'h2b3, 10'h333, 10'h3b3, 10'h2bb,
                               10'h23b, 10'h33b, 10'h3bb,
                               10'h013, 10'h01b, 10'h393, 10'h113, 10'h193, 10'h213,
                               10'h313, 10'h093, 10'h293, 10'h29b, 10'h09b, 10'h0bb};
    if (is_div)      lat_m1 = DIV_M1;
    else if (is_mul) lat_m1 = MUL_M1;
    else             lat_m1 = '0;
  end

  assign can_take = run & ~flush & ((state == IDLE) | ((state == WB) & wb_ready));
  assign in_ready = ~reset | can_take;
  assign accept   = in_valid & can_take;
  assign wb_valid = (state == WB);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capt      = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_nxt = EXEC;
            cnt_nxt   = lat_m1;
          end
        end
        EXEC: begin
          if (cnt == '0) state_nxt = CAPT;
          else           cnt_nxt   = cnt - 1'b1;
        end
        CAPT: begin
          state_nxt = WB;
          capt      = 1'b1;
        end
        WB: begin
          if (wb_ready) begin
            if (accept) begin
              state_nxt = EXEC;
              cnt_nxt   = lat_m1;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Operand registers move only on accept so the ALU inputs never toggle idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_opcode     <= '0;
      alu_regA       <= '0;
      alu_regB       <= '0;
      alu_regDest    <= '0;
      alu_regA_value <= '0;
      alu_regB_value <= '0;
      wr_pend        <= 1'b0;
    end else if (accept) begin
      alu_opcode     <= in_opcode;
      alu_regA       <= in_regA;
      alu_regB       <= in_regB;
      alu_regDest    <= in_regDest;
      alu_regA_value <= in_regA_value;
      alu_regB_value <= in_regB_value;
      wr_pend        <= (in_regDest != 5'd0) & is_sup;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_data  <= '0;
      wb_rd    <= '0;
      wb_wr_en <= 1'b0;
    end else if (capt) begin
      wb_data  <= alu_data_out;
      wb_rd    <= alu_regDest;
      wb_wr_en <= wr_pend;
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a small registered ALU stand-in.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_opcode;
  logic [4:0]  in_regA;
  logic [11:0] in_regB;
  logic [4:0]  in_regDest;
  logic [63:0] in_regA_value;
  logic [63:0] in_regB_value;
  logic [9:0]  alu_opcode;
  logic [4:0]  alu_regA;
  logic [11:0] alu_regB;
  logic [4:0]  alu_regDest;
  logic [63:0] alu_regA_value;
  logic [63:0] alu_regB_value;
  logic [63:0] alu_data_out = '0;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        wb_wr_en;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.MUL_CYCLES(2), .DIV_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_regA(in_regA), .in_regB(in_regB), .in_regDest(in_regDest),
    .in_regA_value(in_regA_value), .in_regB_value(in_regB_value),
    .alu_opcode(alu_opcode), .alu_regA(alu_regA), .alu_regB(alu_regB),
    .alu_regDest(alu_regDest), .alu_regA_value(alu_regA_value), .alu_regB_value(alu_regB_value),
    .alu_data_out(alu_data_out),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_wr_en(wb_wr_en), .busy(busy)
  );

  function automatic logic [63:0] alu_model(input logic [9:0] op, input logic [11:0] rb,
                                            input logic [63:0] a, input logic [63:0] b);
    logic signed [31:0] q;
    case (op)
      10'h013: return a + {{52{rb[11]}}, rb};
      10'h033: return (rb[11:5] == 7'h01) ? a * b : a + b;
      10'h23b: begin
        q = (b[31:0] == 32'd0) ? -32'sd1 : $signed(a[31:0]) / $signed(b[31:0]);
        return {{32{q[31]}}, q};
      end
      default: return a + b;
    endcase
  endfunction

  always @(posedge clk)
    alu_data_out <= alu_model(alu_opcode, alu_regB, alu_regA_value, alu_regB_value);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [9:0] op, input logic [11:0] rb, input logic [4:0] rd,
                       input logic [63:0] va, input logic [63:0] vb);
    logic acc;
    logic done;
    in_opcode     = op;
    in_regA       = 5'd1;
    in_regB       = rb;
    in_regDest    = rd;
    in_regA_value = va;
    in_regB_value = vb;
    in_valid      = 1'b1;
    done          = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) done = 1'b1;
    end
    in_valid = 1'b0;
    chk("issue_accept", done, 1);
  endtask

  // Called just after the accept edge; checks operand hold every waiting cycle
  task automatic wait_wb(input string tag, input int exp_n, input logic [9:0] op,
                         input logic [63:0] va, input logic [63:0] vb);
    int n;
    n = 0;
    while (!wb_valid && n < 40) begin
      chk({tag, "_hold_op"}, alu_opcode, op);
      chk({tag, "_hold_a"}, alu_regA_value, va);
      chk({tag, "_hold_b"}, alu_regB_value, vb);
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, exp_n);
  endtask

  initial begin
    int pulses;
    reset         = 1'b0;
    flush         = 1'b0;
    wb_ready      = 1'b1;
    in_valid      = 1'b1;
    in_opcode     = 10'h013;
    in_regA       = 5'd1;
    in_regB       = 12'hFFF;
    in_regDest    = 5'd3;
    in_regA_value = 64'd5;
    in_regB_value = 64'd0;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_opcode", alu_opcode, 0);
    chk("rst_alu_a", alu_regA_value, 0);
    chk("rst_alu_dest", alu_regDest, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_wr_en", wb_wr_en, 0);

    in_valid = 1'b0;
    reset    = 1'b1;
    repeat (2) tick();

    // ADDI 5 + (-1)
    issue(10'h013, 12'hFFF, 5'd3, 64'd5, 64'd0);
    wait_wb("addi", 2, 10'h013, 64'd5, 64'd0);
    chk("addi_data", wb_data, 64'd4);
    chk("addi_rd", wb_rd, 3);
    chk("addi_wr_en", wb_wr_en, 1);
    tick();
    chk("addi_retired", wb_valid, 0);
    chk("addi_idle", busy, 0);

    // MUL 7*6
    issue(10'h033, 12'h022, 5'd5, 64'd7, 64'd6);
    wait_wb("mul", 3, 10'h033, 64'd7, 64'd6);
    chk("mul_data", wb_data, 64'd42);
    chk("mul_wr_en", wb_wr_en, 1);
    tick();

    // DIVW -20/3
    issue(10'h23b, 12'h003, 5'd6, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3);
    wait_wb("divw", 9, 10'h23b, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3);
    chk("divw_data", wb_data, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("divw_rd", wb_rd, 6);
    tick();

    // Writeback backpressure with a pending op
    wb_ready = 1'b0;
    issue(10'h033, 12'h002, 5'd7, 64'd10, 64'd20);
    wait_wb("bp1", 2, 10'h033, 64'd10, 64'd20);
    in_opcode     = 10'h033;
    in_regB       = 12'h002;
    in_regDest    = 5'd8;
    in_regA_value = 64'd1;
    in_regB_value = 64'd2;
    in_valid      = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_wb_valid", wb_valid, 1);
      chk("bp_wb_data", wb_data, 64'd30);
      chk("bp_wb_rd", wb_rd, 7);
      tick();
    end
    wb_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_busy", busy, 1);
    chk("bp_next_a", alu_regA_value, 64'd1);
    wait_wb("bp2", 2, 10'h033, 64'd1, 64'd2);
    chk("bp2_data", wb_data, 64'd3);
    chk("bp2_rd", wb_rd, 8);
    tick();

    // rd=0 and unsupported opcode both retire without a write
    issue(10'h033, 12'h002, 5'd0, 64'd4, 64'd4);
    wait_wb("rd0", 2, 10'h033, 64'd4, 64'd4);
    chk("rd0_wr_en", wb_wr_en, 0);
    tick();
    issue(10'h3FF, 12'h000, 5'd4, 64'd9, 64'd1);
    wait_wb("unsup", 2, 10'h3FF, 64'd9, 64'd1);
    chk("unsup_wr_en", wb_wr_en, 0);
    chk("unsup_rd", wb_rd, 4);
    tick();

    // Flush in the 4th EXEC cycle of a DIV
    issue(10'h233, 12'h020, 5'd2, 64'd100, 64'd7);
    repeat (3) tick();
    chk("fl_busy_before", busy, 1);
    flush         = 1'b1;
    in_opcode     = 10'h033;
    in_regB       = 12'h002;
    in_regDest    = 5'd9;
    in_valid      = 1'b1;
    #1;
    chk("fl_in_ready", in_ready, 0);
    tick();
    chk("fl_idle", busy, 0);
    chk("fl_wb_valid", wb_valid, 0);
    chk("fl_in_ready2", in_ready, 0);
    tick();
    chk("fl_no_accept", busy, 0);
    flush    = 1'b0;
    in_valid = 1'b0;
    pulses   = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (wb_valid) pulses++;
    end
    chk("fl_no_wb", pulses, 0);

    // Asynchronous reset while holding a result in WB
    wb_ready = 1'b0;
    issue(10'h033, 12'h002, 5'd9, 64'd3, 64'd4);
    wait_wb("rwb", 2, 10'h033, 64'd3, 64'd4);
    chk("rwb_valid_before", wb_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rwb_wb_valid", wb_valid, 0);
    chk("rwb_busy", busy, 0);
    chk("rwb_in_ready", in_ready, 1);
    chk("rwb_alu_opcode", alu_opcode, 0);
    chk("rwb_alu_a", alu_regA_value, 0);
    chk("rwb_alu_dest", alu_regDest, 0);
    chk("rwb_wb_data", wb_data, 0);
    chk("rwb_wb_rd", wb_rd, 0);
    chk("rwb_wb_wr_en", wb_wr_en, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
